// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with programmable modulus, parallel load and
// wrap-or-saturate boundary handling; ovf can drive the next stage's en.
module updown_counter_n #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter bit          SAT_MODE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             ovf,
  output logic             tc,
  output logic             zero
);

  localparam longint unsigned FULL_L = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_L  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ZERO_L = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_L  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Reject parameter sets the counter cannot honour
  if (WIDTH < 2 || MAX_VAL == 0 || longint'(MAX_VAL) > FULL_L || RST_VAL > MAX_VAL) begin : g_bad_params
    $error("updown_counter_n: illegal WIDTH/MAX_VAL/RST_VAL combination");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;

  // Next-state: load beats count; a step past a boundary wraps or saturates and flags ovf
  always_comb begin
    q_nxt_s   = q_r;
    ovf_nxt_s = 1'b0;
    if (load) begin
      q_nxt_s = (load_val > MAX_L) ? MAX_L : load_val;
    end else if (en) begin
      if (up) begin
        if (q_r >= MAX_L) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = SAT_MODE ? MAX_L : ZERO_L;
        end else begin
          q_nxt_s = q_r + ONE_L;
        end
      end else begin
        if (q_r == ZERO_L) begin
          ovf_nxt_s = 1'b1;
          q_nxt_s   = SAT_MODE ? ZERO_L : MAX_L;
        end else begin
          q_nxt_s = q_r - ONE_L;
        end
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r   <= RST_L;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign Q    = q_r;
  assign ovf  = ovf_r;
  // tc tracks the live direction so it always predicts the next enabled step
  assign tc   = up ? (q_r == MAX_L) : (q_r == ZERO_L);
  assign zero = (q_r == ZERO_L);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed, table-driven bench for updown_counter_n using three configurations
// (mod-10 wrap, 4-bit saturate, mod-10 wrap with non-zero reset value).
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q_a, q_b, q_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       tc_a, tc_b, tc_c;
  logic       zero_a, zero_b, zero_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1'b0), .RST_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .Q(q_a), .ovf(ovf_a), .tc(tc_a), .zero(zero_a));

  updown_counter_n #(.WIDTH(4), .MAX_VAL(15), .SAT_MODE(1'b1), .RST_VAL(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .Q(q_b), .ovf(ovf_b), .tc(tc_b), .zero(zero_b));

  updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1'b0), .RST_VAL(5)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .Q(q_c), .ovf(ovf_c), .tc(tc_c), .zero(zero_c));

  typedef struct {
    int         sel;
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic [3:0] q;
    logic       ovf;
    logic       tc;
    logic       zero;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int sel, logic r, logic l, logic e, logic u, logic [3:0] lv,
                              logic [3:0] q, logic o, logic t, logic z);
    vec_t v;
    v.sel = sel; v.rst = r; v.load = l; v.en = e; v.up = u; v.lv = lv;
    v.q = q; v.ovf = o; v.tc = t; v.zero = z;
    vq.push_back(v);
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_dut(int sel, int idx, logic [3:0] q, logic o, logic t, logic z);
    logic [3:0] aq;
    logic       ao, at, az;
    case (sel)
      0:       begin aq = q_a; ao = ovf_a; at = tc_a; az = zero_a; end
      1:       begin aq = q_b; ao = ovf_b; at = tc_b; az = zero_b; end
      default: begin aq = q_c; ao = ovf_c; at = tc_c; az = zero_c; end
    endcase
    check("q", idx, int'(aq), int'(q));
    check("ovf", idx, int'(ao), int'(o));
    check("tc", idx, int'(at), int'(t));
    check("zero", idx, int'(az), int'(z));
  endtask

  initial begin
    int q;
    // mod-10 up count from reset, with en high during reset
    add(0, 0,0,1,1, 4'd0, 4'd0,0,0,1);
    add(0, 0,0,1,1, 4'd0, 4'd0,0,0,1);
    for (int i = 1; i <= 12; i++) begin
      q = i % 10;
      add(0, 1,0,1,1, 4'd0, 4'(q), i == 10, q == 9, q == 0);
    end
    // mod-10 down count from reset
    add(0, 0,0,1,0, 4'd0, 4'd0,0,1,1);
    for (int i = 1; i <= 11; i++) begin
      q = (20 - i) % 10;
      add(0, 1,0,1,0, 4'd0, 4'(q), (i == 1) || (i == 11), q == 0, q == 0);
    end
    // saturating config: top then bottom boundary
    add(1, 1,1,0,1, 4'd14, 4'd14,0,0,0);
    add(1, 1,0,1,1, 4'd0, 4'd15,0,1,0);
    add(1, 1,0,1,1, 4'd0, 4'd15,1,1,0);
    add(1, 1,0,1,1, 4'd0, 4'd15,1,1,0);
    add(1, 1,0,1,1, 4'd0, 4'd15,1,1,0);
    add(1, 1,0,1,0, 4'd0, 4'd14,0,0,0);
    add(1, 1,1,0,0, 4'd1, 4'd1,0,0,0);
    add(1, 1,0,1,0, 4'd0, 4'd0,0,1,1);
    add(1, 1,0,1,0, 4'd0, 4'd0,1,1,1);
    add(1, 1,0,1,0, 4'd0, 4'd0,1,1,1);
    add(1, 1,0,0,0, 4'd0, 4'd0,0,1,1);
    // load clamp and load-over-boundary priority
    add(0, 1,1,1,1, 4'd12, 4'd9,0,1,0);
    add(0, 1,0,1,1, 4'd0, 4'd0,1,0,1);
    add(0, 1,1,1,0, 4'd15, 4'd9,0,0,0);
    add(0, 1,1,1,1, 4'd9, 4'd9,0,1,0);
    add(0, 1,1,0,1, 4'd10, 4'd9,0,1,0);
    // reset beats load; reset at a would-be boundary step
    add(2, 0,1,1,1, 4'd7, 4'd5,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd6,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd7,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd8,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd9,0,1,0);
    add(2, 0,0,1,1, 4'd0, 4'd5,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd6,0,0,0);
    add(2, 1,0,1,1, 4'd0, 4'd7,0,0,0);
    // enable gating with direction toggling
    add(0, 1,1,0,1, 4'd3, 4'd3,0,0,0);
    add(0, 1,0,1,1, 4'd0, 4'd4,0,0,0);
    add(0, 1,0,0,1, 4'd0, 4'd4,0,0,0);
    add(0, 1,0,1,0, 4'd0, 4'd3,0,0,0);
    add(0, 1,0,0,0, 4'd0, 4'd3,0,0,0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; load = vq[i].load; en = vq[i].en; up = vq[i].up; load_val = vq[i].lv;
      @(posedge clk);
      #1;
      check_dut(vq[i].sel, i, vq[i].q, vq[i].ovf, vq[i].tc, vq[i].zero);
    end

    // rst low between edges must not disturb Q until the next edge
    @(negedge clk);
    rst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b0; up = 1'b1;
    @(posedge clk);
    #1;
    check("c_load", 100, int'(q_c), 7);
    @(negedge clk);
    load = 1'b0; en = 1'b1; rst = 1'b0;
    #2;
    check("c_async", 101, int'(q_c), 7);
    @(posedge clk);
    #1;
    check("c_rst", 102, int'(q_c), 5);
    check("c_rst_ovf", 103, int'(ovf_c), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("c_resume", 104, int'(q_c), 6);
    @(posedge clk);
    #1;
    check("c_resume", 105, int'(q_c), 7);

    // tc follows up combinationally, without a clock edge
    @(negedge clk);
    load = 1'b1; load_val = 4'd9; en = 1'b0;
    @(negedge clk);
    load = 1'b0; up = 1'b1;
    #1;
    check("tc_up", 106, int'(tc_a), 1);
    up = 1'b0;
    #1;
    check("tc_dn", 107, int'(tc_a), 0);
    load = 1'b1; load_val = 4'd0;
    @(negedge clk);
    load = 1'b0;
    #1;
    check("tc_dn0", 108, int'(tc_a), 1);
    up = 1'b1;
    #1;
    check("tc_up0", 109, int'(tc_a), 0);
    check("zero0", 110, int'(zero_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
